// File: rtl/mac_lookup_requester_pkg.sv
// Shared widths, broadcast key, FSM encoding and forwarding-decision payload
// for the MAC table requester.
package mac_lookup_requester_pkg;

    localparam int unsigned pADRESS = 2;
    localparam int unsigned pPORTS  = 1 << pADRESS;
    localparam int unsigned pMAC_W  = 14;
    localparam int unsigned CNT_W   = 3;

    localparam logic [pMAC_W-1:0] MAC_BCAST = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [pADRESS-1:0] src;
        logic [pADRESS-1:0] dst;
        logic               flood;
        logic               drop;
    } fwd_t;

    // Broadcast wins over the table result; a hit on the source port is dropped.
    function automatic fwd_t fwd_decide(input logic [pMAC_W-1:0]  da,
                                        input logic [pADRESS-1:0] hit,
                                        input logic [pADRESS-1:0] src);
        fwd_t f;
        f.src   = src;
        f.dst   = hit;
        f.flood = 1'b0;
        f.drop  = 1'b0;
        if (da == MAC_BCAST) begin
            f.dst   = '0;
            f.flood = 1'b1;
        end else if (hit == src) begin
            f.drop = 1'b1;
        end
        return f;
    endfunction

endpackage

// File: rtl/mac_lookup_requester_rr_arbiter.sv
// Combinational round-robin pick: first requesting port at or after the
// pointer, wrapping modulo the port count.
module mac_lookup_requester_rr_arbiter
    import mac_lookup_requester_pkg::*;
(
    input  logic [pPORTS-1:0]  req_i,
    input  logic [pADRESS-1:0] ptr_i,
    output logic [pPORTS-1:0]  gnt_o,
    output logic [pADRESS-1:0] idx_o,
    output logic               any_o
);

    logic [pADRESS-1:0] cand;

    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int unsigned i = 0; i < pPORTS; i++) begin
            cand = ptr_i + pADRESS'(i);
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
        gnt_o = any_o ? (pPORTS'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/mac_lookup_requester.sv
// Initiator of MAC table learn+lookup transactions: arbitrates ingress
// headers, issues one table access at a time and hands the decision on.
module mac_lookup_requester
    import mac_lookup_requester_pkg::*;
#(
    parameter int unsigned pLOOKUP_LAT = 1
) (
    input  logic                       iclk,
    input  logic                       i_rst_n,
    input  logic [pPORTS-1:0]          i_hdr_valid,
    input  logic [pPORTS*pMAC_W-1:0]   i_hdr_sa,
    input  logic [pPORTS*pMAC_W-1:0]   i_hdr_da,
    output logic [pPORTS-1:0]          o_hdr_ready,
    output logic                       o_write_enable,
    output logic [pADRESS-1:0]         o_port_num,
    output logic [pMAC_W-1:0]          o_MAC_SA,
    output logic [pMAC_W-1:0]          o_MAC_DA,
    input  logic [pADRESS-1:0]         i_port_num,
    output logic                       o_fwd_valid,
    input  logic                       i_fwd_ready,
    output logic [pADRESS-1:0]         o_fwd_src,
    output logic [pADRESS-1:0]         o_fwd_dst,
    output logic                       o_fwd_flood,
    output logic                       o_fwd_drop
);

    state_e             state_q, state_d;
    logic [pADRESS-1:0] rr_q, rr_d;
    logic [pADRESS-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [pMAC_W-1:0]  sa_q, sa_d;
    logic [pMAC_W-1:0]  da_q, da_d;
    logic [pPORTS-1:0]  ready_q, ready_d;
    logic               we_q, we_d;
    logic               fwd_valid_q, fwd_valid_d;
    fwd_t               fwd_q, fwd_d;

    logic [pPORTS-1:0]  arb_gnt;
    logic [pADRESS-1:0] arb_idx;
    logic               arb_any;
    logic               lookup_done;

    mac_lookup_requester_rr_arbiter u_arb (
        .req_i (i_hdr_valid),
        .ptr_i (rr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    assign lookup_done = (cnt_q <= CNT_W'(1));

    // State register
    always_ff @(posedge iclk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_any) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (lookup_done) state_d = RESP;
            RESP:    if (i_fwd_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values; keys are latched at grant so the
    // transaction survives a requester dropping valid.
    always_comb begin
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        sa_d        = sa_q;
        da_d        = da_q;
        ready_d     = '0;
        we_d        = 1'b0;
        fwd_valid_d = fwd_valid_q;
        fwd_d       = fwd_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    gnt_d   = arb_idx;
                    sa_d    = i_hdr_sa[32'(arb_idx) * pMAC_W +: pMAC_W];
                    da_d    = i_hdr_da[32'(arb_idx) * pMAC_W +: pMAC_W];
                    ready_d = arb_gnt;
                    we_d    = 1'b1;
                end
            end
            ISSUE: begin
                rr_d  = gnt_q + pADRESS'(1);
                cnt_d = CNT_W'(pLOOKUP_LAT);
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (lookup_done) begin
                    fwd_d       = fwd_decide(da_q, i_port_num, gnt_q);
                    fwd_valid_d = 1'b1;
                end
            end
            RESP: begin
                if (i_fwd_ready) fwd_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_q        <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            sa_q        <= '0;
            da_q        <= '0;
            ready_q     <= '0;
            we_q        <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_q       <= '0;
        end else begin
            rr_q        <= rr_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            sa_q        <= sa_d;
            da_q        <= da_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_q       <= fwd_d;
        end
    end

    assign o_hdr_ready    = ready_q;
    assign o_write_enable = we_q;
    assign o_port_num     = gnt_q;
    assign o_MAC_SA       = sa_q;
    assign o_MAC_DA       = da_q;
    assign o_fwd_valid    = fwd_valid_q;
    assign o_fwd_src      = fwd_q.src;
    assign o_fwd_dst      = fwd_q.dst;
    assign o_fwd_flood    = fwd_q.flood;
    assign o_fwd_drop     = fwd_q.drop;

endmodule

// File: tb/tb_mac_lookup_requester.sv
// Self-checking bench for mac_lookup_requester: default-latency instance plus
// a latency-4 instance for the mid-lookup reset scenario.
module tb_mac_lookup_requester;
    import mac_lookup_requester_pkg::*;

    localparam int unsigned P     = pPORTS;
    localparam int unsigned W     = pMAC_W;
    localparam int unsigned A     = pADRESS;
    localparam int unsigned LAT_A = 1;
    localparam int unsigned LAT_B = 4;

    logic           iclk;
    logic           i_rst_n;
    logic [P-1:0]   i_hdr_valid;
    logic [P*W-1:0] i_hdr_sa, i_hdr_da;
    logic [A-1:0]   i_port_num;
    logic           i_fwd_ready;

    logic [P-1:0] hdr_ready,  hdr_ready4;
    logic         we,         we4;
    logic [A-1:0] port_num,   port_num4;
    logic [W-1:0] mac_sa,     mac_sa4, mac_da, mac_da4;
    logic         fwd_valid,  fwd_valid4;
    logic [A-1:0] fwd_src,    fwd_src4, fwd_dst, fwd_dst4;
    logic         fwd_flood,  fwd_flood4, fwd_drop, fwd_drop4;

    mac_lookup_requester #(.pLOOKUP_LAT(LAT_A)) dut (
        .iclk(iclk), .i_rst_n(i_rst_n), .i_hdr_valid(i_hdr_valid),
        .i_hdr_sa(i_hdr_sa), .i_hdr_da(i_hdr_da), .o_hdr_ready(hdr_ready),
        .o_write_enable(we), .o_port_num(port_num), .o_MAC_SA(mac_sa),
        .o_MAC_DA(mac_da), .i_port_num(i_port_num), .o_fwd_valid(fwd_valid),
        .i_fwd_ready(i_fwd_ready), .o_fwd_src(fwd_src), .o_fwd_dst(fwd_dst),
        .o_fwd_flood(fwd_flood), .o_fwd_drop(fwd_drop)
    );

    mac_lookup_requester #(.pLOOKUP_LAT(LAT_B)) dut4 (
        .iclk(iclk), .i_rst_n(i_rst_n), .i_hdr_valid(i_hdr_valid),
        .i_hdr_sa(i_hdr_sa), .i_hdr_da(i_hdr_da), .o_hdr_ready(hdr_ready4),
        .o_write_enable(we4), .o_port_num(port_num4), .o_MAC_SA(mac_sa4),
        .o_MAC_DA(mac_da4), .i_port_num(i_port_num), .o_fwd_valid(fwd_valid4),
        .i_fwd_ready(i_fwd_ready), .o_fwd_src(fwd_src4), .o_fwd_dst(fwd_dst4),
        .o_fwd_flood(fwd_flood4), .o_fwd_drop(fwd_drop4)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    int n_vec = 0;
    int n_err = 0;
    int ptr_m = 0;
    int cyc   = 0;
    logic [W-1:0] sa_m [P];
    logic [W-1:0] da_m [P];

    always @(posedge iclk) cyc <= cyc + 1;

    task automatic tick();
        @(negedge iclk);
    endtask

    task automatic drive_keys();
        for (int k = 0; k < P; k++) begin
            i_hdr_sa[k*W +: W] = sa_m[k];
            i_hdr_da[k*W +: W] = da_m[k];
        end
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        i_hdr_valid = '0;
        repeat (2) tick();
        i_rst_n = 1'b1;
        ptr_m = 0;
        tick();
    endtask

    // Reference: first valid port scanning upward from the pointer, wrapping.
    function automatic int model_grant(input logic [P-1:0] v, input int p);
        for (int i = 0; i < P; i++)
            if (v[(p + i) % P]) return (p + i) % P;
        return -1;
    endfunction

    // Reference decision as a packed {src, dst, flood, drop} word.
    function automatic logic [2*A+1:0] model_fwd(input logic [W-1:0] da, input int hit, input int src);
        logic [W-1:0] bcast;
        bcast = '1;
        if (da == bcast) return {A'(src), A'(0), 1'b1, 1'b0};
        if (hit == src)  return {A'(src), A'(hit), 1'b0, 1'b1};
        return {A'(src), A'(hit), 1'b0, 1'b0};
    endfunction

    task automatic wait_issue(input bit on4, output int k, output bit saw_fwd);
        k = 0;
        saw_fwd = 1'b0;
        while (((on4 ? hdr_ready4 : hdr_ready) === '0) && k < 30) begin
            tick();
            k++;
            if ((on4 ? fwd_valid4 : fwd_valid) === 1'b1) saw_fwd = 1'b1;
        end
    endtask

    task automatic wait_fwd(input bit on4, output int k);
        k = 0;
        while (((on4 ? fwd_valid4 : fwd_valid) !== 1'b1) && k < 30) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_hdr_valid = '0;
        i_fwd_ready = 1'b1;
        i_port_num = '0;
        for (int k = 0; k < P; k++) begin sa_m[k] = '0; da_m[k] = '0; end
        drive_keys();
        repeat (3) tick();
        n_vec++;
        if ({hdr_ready, we, port_num, mac_sa, mac_da, fwd_valid, fwd_src, fwd_dst, fwd_flood, fwd_drop} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ready=%b we=%b fwd_valid=%b sa=%h, required all zero", hdr_ready, we, fwd_valid, mac_sa);
        end
        n_vec++;
        if ({hdr_ready4, we4, port_num4, mac_sa4, mac_da4, fwd_valid4, fwd_src4, fwd_dst4, fwd_flood4, fwd_drop4} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs_lat4: got ready=%b we=%b fwd_valid=%b, required all zero", hdr_ready4, we4, fwd_valid4);
        end
        i_rst_n = 1'b1;
        ptr_m = 0;
        repeat (2) tick();
        n_vec++;
        if ({hdr_ready, we, fwd_valid} !== '0) begin
            n_err++;
            $display("FAIL idle_after_reset: got ready=%b we=%b fwd_valid=%b, required 0", hdr_ready, we, fwd_valid);
        end
    endtask

    task automatic test_single();
        int g, k;
        bit sf;
        sa_m[2] = W'(16'h0005);
        da_m[2] = W'(16'h0011);
        drive_keys();
        i_port_num = '0;
        i_hdr_valid = 4'b0100;
        g = model_grant(i_hdr_valid, ptr_m);
        wait_issue(1'b0, k, sf);
        n_vec++;
        if ({hdr_ready, we, port_num, mac_sa, mac_da} !== {P'(1) << g, 1'b1, A'(g), sa_m[g], da_m[g]}) begin
            n_err++;
            $display("FAIL single_issue: got ready=%b we=%b port=%0d sa=%h da=%h, required ready=%b we=1 port=%0d sa=%h da=%h",
                     hdr_ready, we, port_num, mac_sa, mac_da, P'(1) << g, g, sa_m[g], da_m[g]);
        end
        ptr_m = (g + 1) % P;
        i_hdr_valid = '0;
        tick();
        n_vec++;
        if ({hdr_ready, we, port_num, mac_sa, mac_da} !== {P'(0), 1'b0, A'(g), sa_m[g], da_m[g]}) begin
            n_err++;
            $display("FAIL single_wait_hold: got ready=%b we=%b port=%0d sa=%h da=%h, required we=0 keys held", hdr_ready, we, port_num, mac_sa, mac_da);
        end
        i_port_num = A'(3);
        wait_fwd(1'b0, k);
        n_vec++;
        if (k + 1 != int'(LAT_A) + 1) begin
            n_err++;
            $display("FAIL single_latency: got %0d cycles, required %0d", k + 1, LAT_A + 1);
        end
        n_vec++;
        if ({fwd_valid, fwd_src, fwd_dst, fwd_flood, fwd_drop} !== {1'b1, model_fwd(da_m[g], 3, g)}) begin
            n_err++;
            $display("FAIL single_decision: got v=%b src=%0d dst=%0d fl=%b dr=%b, required %b", fwd_valid, fwd_src, fwd_dst, fwd_flood, fwd_drop, {1'b1, model_fwd(da_m[g], 3, g)});
        end
        tick();
        n_vec++;
        if (fwd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_release: got fwd_valid=%b, required 0", fwd_valid);
        end
    endtask

    task automatic test_round_robin();
        int g, k, hit, last;
        bit sf;
        logic [W-1:0] e_da;
        apply_reset();
        i_fwd_ready = 1'b1;
        for (int p = 0; p < P; p++) begin
            sa_m[p] = W'($urandom);
            da_m[p] = W'($urandom);
        end
        drive_keys();
        i_port_num = A'($urandom_range(0, P - 1));
        i_hdr_valid = '1;
        last = -1;
        for (int n = 0; n < 8; n++) begin
            g = model_grant(i_hdr_valid, ptr_m);
            wait_issue(1'b0, k, sf);
            n_vec++;
            if ({hdr_ready, we, port_num, mac_sa, mac_da} !== {P'(1) << g, 1'b1, A'(g), sa_m[g], da_m[g]}) begin
                n_err++;
                $display("FAIL rr_grant_%0d: got ready=%b port=%0d sa=%h da=%h, required ready=%b port=%0d sa=%h da=%h",
                         n, hdr_ready, port_num, mac_sa, mac_da, P'(1) << g, g, sa_m[g], da_m[g]);
            end
            if (last >= 0) begin
                n_vec++;
                if (cyc - last != int'(LAT_A) + 3) begin
                    n_err++;
                    $display("FAIL rr_spacing_%0d: got %0d cycles, required %0d", n, cyc - last, LAT_A + 3);
                end
            end
            last = cyc;
            e_da = da_m[g];
            hit = $urandom_range(0, P - 1);
            i_port_num = A'(hit);
            for (int p = 0; p < P; p++) begin
                sa_m[p] = W'($urandom);
                da_m[p] = ($urandom_range(0, 3) == 0) ? MAC_BCAST : W'($urandom);
            end
            drive_keys();
            wait_fwd(1'b0, k);
            n_vec++;
            if ({fwd_valid, fwd_src, fwd_dst, fwd_flood, fwd_drop} !== {1'b1, model_fwd(e_da, hit, g)}) begin
                n_err++;
                $display("FAIL rr_decision_%0d: got v=%b src=%0d dst=%0d fl=%b dr=%b, required %b",
                         n, fwd_valid, fwd_src, fwd_dst, fwd_flood, fwd_drop, {1'b1, model_fwd(e_da, hit, g)});
            end
            ptr_m = (g + 1) % P;
        end
        i_hdr_valid = '0;
        repeat (3) tick();
    endtask

    task automatic test_broadcast();
        int g, k;
        bit sf;
        sa_m[1] = W'($urandom);
        da_m[1] = MAC_BCAST;
        drive_keys();
        i_port_num = A'(1);
        i_hdr_valid = 4'b0010;
        g = model_grant(i_hdr_valid, ptr_m);
        wait_issue(1'b0, k, sf);
        n_vec++;
        if ({hdr_ready, we, port_num, mac_sa} !== {P'(1) << g, 1'b1, A'(g), sa_m[g]}) begin
            n_err++;
            $display("FAIL bcast_learn: got ready=%b we=%b port=%0d sa=%h, required ready=%b we=1 port=%0d sa=%h", hdr_ready, we, port_num, mac_sa, P'(1) << g, g, sa_m[g]);
        end
        ptr_m = (g + 1) % P;
        i_hdr_valid = '0;
        wait_fwd(1'b0, k);
        n_vec++;
        if ({fwd_valid, fwd_src, fwd_dst, fwd_flood, fwd_drop} !== {1'b1, model_fwd(da_m[g], 1, g)}) begin
            n_err++;
            $display("FAIL bcast_decision: got v=%b src=%0d dst=%0d fl=%b dr=%b, required %b", fwd_valid, fwd_src, fwd_dst, fwd_flood, fwd_drop, {1'b1, model_fwd(da_m[g], 1, g)});
        end
        repeat (2) tick();
    endtask

    task automatic test_self_forward();
        int g, k;
        bit sf;
        sa_m[3] = W'($urandom);
        da_m[3] = W'(16'h0020);
        drive_keys();
        i_port_num = A'(3);
        i_hdr_valid = 4'b1000;
        g = model_grant(i_hdr_valid, ptr_m);
        wait_issue(1'b0, k, sf);
        n_vec++;
        if ({hdr_ready, we, port_num} !== {P'(1) << g, 1'b1, A'(g)}) begin
            n_err++;
            $display("FAIL self_issue: got ready=%b we=%b port=%0d, required ready=%b we=1 port=%0d", hdr_ready, we, port_num, P'(1) << g, g);
        end
        ptr_m = (g + 1) % P;
        i_hdr_valid = '0;
        wait_fwd(1'b0, k);
        n_vec++;
        if ({fwd_valid, fwd_src, fwd_dst, fwd_flood, fwd_drop} !== {1'b1, model_fwd(da_m[g], 3, g)}) begin
            n_err++;
            $display("FAIL self_decision: got v=%b src=%0d dst=%0d fl=%b dr=%b, required %b", fwd_valid, fwd_src, fwd_dst, fwd_flood, fwd_drop, {1'b1, model_fwd(da_m[g], 3, g)});
        end
        repeat (2) tick();
    endtask

    task automatic test_backpressure();
        int g, k;
        bit sf;
        logic [2*A+1:0] exp_fwd;
        i_fwd_ready = 1'b0;
        sa_m[2] = W'($urandom);
        da_m[2] = W'($urandom_range(0, 16'h3FFE));
        drive_keys();
        i_port_num = '0;
        i_hdr_valid = 4'b0100;
        g = model_grant(i_hdr_valid, ptr_m);
        wait_issue(1'b0, k, sf);
        n_vec++;
        if (hdr_ready !== P'(1) << g) begin
            n_err++;
            $display("FAIL bp_first_grant: got %b, required %b", hdr_ready, P'(1) << g);
        end
        ptr_m = (g + 1) % P;
        i_hdr_valid = 4'b0011;
        exp_fwd = model_fwd(da_m[g], 0, g);
        wait_fwd(1'b0, k);
        for (int c = 0; c < 10; c++) begin
            n_vec++;
            if ({fwd_valid, fwd_src, fwd_dst, fwd_flood, fwd_drop, hdr_ready} !== {1'b1, exp_fwd, P'(0)}) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got v=%b fwd=%b ready=%b, required v=1 fwd=%b ready=0",
                         c, fwd_valid, {fwd_src, fwd_dst, fwd_flood, fwd_drop}, hdr_ready, exp_fwd);
            end
            tick();
        end
        i_fwd_ready = 1'b1;
        tick();
        n_vec++;
        if ({fwd_valid, hdr_ready} !== {1'b0, P'(0)}) begin
            n_err++;
            $display("FAIL bp_release: got v=%b ready=%b, required v=0 ready=0", fwd_valid, hdr_ready);
        end
        g = model_grant(i_hdr_valid, ptr_m);
        wait_issue(1'b0, k, sf);
        n_vec++;
        if (hdr_ready !== P'(1) << g) begin
            n_err++;
            $display("FAIL bp_next_grant: got %b, required %b", hdr_ready, P'(1) << g);
        end
        ptr_m = (g + 1) % P;
        i_hdr_valid = '0;
        wait_fwd(1'b0, k);
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_wait();
        int k;
        bit sf;
        logic [2*A+1:0] exp_fwd;
        apply_reset();
        i_fwd_ready = 1'b1;
        for (int p = 0; p < P; p++) begin
            sa_m[p] = W'($urandom);
            da_m[p] = W'($urandom_range(0, 16'h3FFE));
        end
        drive_keys();
        i_hdr_valid = 4'b0010;
        wait_issue(1'b1, k, sf);
        n_vec++;
        if ({hdr_ready4, we4} !== {4'b0010, 1'b1}) begin
            n_err++;
            $display("FAIL rst_pre_issue: got ready=%b we=%b, required 0010 1", hdr_ready4, we4);
        end
        i_hdr_valid = '0;
        repeat (2) tick();
        n_vec++;
        if ({we4, port_num4, fwd_valid4} !== {1'b0, A'(1), 1'b0}) begin
            n_err++;
            $display("FAIL rst_in_wait: got we=%b port=%0d v=%b, required we=0 port=1 v=0", we4, port_num4, fwd_valid4);
        end
        i_rst_n = 1'b0;
        #1;
        n_vec++;
        if ({hdr_ready4, we4, port_num4, mac_sa4, mac_da4, fwd_valid4, fwd_src4, fwd_dst4, fwd_flood4, fwd_drop4} !== '0) begin
            n_err++;
            $display("FAIL rst_immediate: got we=%b port=%0d sa=%h v=%b, required all zero", we4, port_num4, mac_sa4, fwd_valid4);
        end
        i_hdr_valid = 4'b1010;
        i_port_num = '0;
        repeat (2) tick();
        i_rst_n = 1'b1;
        wait_issue(1'b1, k, sf);
        n_vec++;
        if ({hdr_ready4, sf} !== {P'(1) << model_grant(4'b1010, 0), 1'b0}) begin
            n_err++;
            $display("FAIL rst_regrant: got ready=%b stray_fwd=%b, required ready=%b stray_fwd=0", hdr_ready4, sf, P'(1) << model_grant(4'b1010, 0));
        end
        i_hdr_valid = '0;
        repeat (LAT_B) tick();
        i_port_num = A'(3);
        wait_fwd(1'b1, k);
        exp_fwd = model_fwd(da_m[1], 3, 1);
        n_vec++;
        if ({fwd_valid4, fwd_src4, fwd_dst4, fwd_flood4, fwd_drop4} !== {1'b1, exp_fwd} || int'(LAT_B) + k != int'(LAT_B) + 1) begin
            n_err++;
            $display("FAIL rst_lat4_decision: got v=%b fwd=%b after %0d cycles, required fwd=%b after %0d",
                     fwd_valid4, {fwd_src4, fwd_dst4, fwd_flood4, fwd_drop4}, LAT_B + k, exp_fwd, LAT_B + 1);
        end
        tick();
        n_vec++;
        if (fwd_valid4 !== 1'b0) begin
            n_err++;
            $display("FAIL rst_lat4_release: got v=%b, required 0", fwd_valid4);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_broadcast();
        test_self_forward();
        test_backpressure();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mac_lookup_requester.md
Name: mac_lookup_requester

Overview:
- Initiator side of the MAC table interface.
- Collects parsed frame headers (SA, DA) from pPORTS ingress ports and arbitrates between them round-robin.
- Issues one learn+lookup transaction at a time to MAC_table: SA is learned against the source port, and DA is looked up.
- Returns the forwarding decision (destination port, flood, or drop) to the switch fabric with a valid/ready handshake.

Parameters:
- pADRESS, 2, width of port index; same meaning as in MAC_table.
- pPORTS, 4, number of ingress ports; must equal 2**pADRESS.
- pMAC_W, 14, width of SA/DA key presented to MAC_table.
- pLOOKUP_LAT, 1, cycles from the table write_enable edge to a valid i_port_num (range 1..7).

Ports:
- iclk  in  1  system clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_hdr_valid  in  pPORTS  per-port header valid.
- i_hdr_sa  in  pPORTS*pMAC_W  per-port source MAC key; port k occupies bits [k*pMAC_W +: pMAC_W].
- i_hdr_da  in  pPORTS*pMAC_W  per-port destination MAC key; same packing as i_hdr_sa.
- o_hdr_ready  out  pPORTS  one-hot accept pulse.
- o_write_enable  out  1  to MAC_table i_write_enable.
- o_port_num  out  pADRESS  to MAC_table i_port_num (source port).
- o_MAC_SA  out  pMAC_W  to MAC_table i_MAC_SA.
- o_MAC_DA  out  pMAC_W  to MAC_table i_MAC_DA.
- i_port_num  in  pADRESS  from MAC_table o_port_num (lookup result).
- o_fwd_valid  out  1  decision valid.
- i_fwd_ready  in  1  fabric accepts decision.
- o_fwd_src  out  pADRESS  source port of decision.
- o_fwd_dst  out  pADRESS  destination port; 0 when flood is set.
- o_fwd_flood  out  1  broadcast DA; send to all ports except the source.
- o_fwd_drop  out  1  destination equals source; discard.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, rr pointer 0, wait counter 0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any i_hdr_valid is set, grant g = first valid port at or after the rr pointer, wrapping modulo pPORTS.
  - Latch SA[g] and DA[g], then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE, exactly 1 cycle:
  - o_write_enable=1, o_port_num=g, o_MAC_SA/o_MAC_DA=latched keys, o_hdr_ready[g]=1; all other ready bits 0.
  - rr pointer <= (g+1) mod pPORTS.
  - Wait counter loads pLOOKUP_LAT.
  - Next state is WAIT.
- WAIT:
  - o_write_enable=0; o_MAC_SA, o_MAC_DA and o_port_num are held stable.
  - Counter decrements each cycle. On the cycle it reaches 0, capture i_port_num and go to RESP.
  - Net: i_port_num is sampled pLOOKUP_LAT+1 edges after the ISSUE edge.
- Decision computation:
  - DA == all-ones: flood=1, dst=0, drop=0, regardless of i_port_num.
  - Else if captured port == g: drop=1, flood=0, dst=g.
  - Else: dst = captured port, flood=0, drop=0.
- RESP:
  - o_fwd_valid=1 with src=g and the decision fields held stable until i_fwd_ready=1 is sampled.
  - On that edge, o_fwd_valid drops and the FSM returns to IDLE.
  - A new grant is possible at the earliest in the IDLE cycle that follows.
- Throughput: at most one header per (pLOOKUP_LAT+3) cycles with ready tied high.
- i_hdr_valid deasserted before its ready pulse: no transaction is lost for ports not granted. A grant decided in IDLE always completes, because keys are latched in IDLE.
- Learn always happens, including for flood and drop cases.
- Simultaneous valids on all ports with pointer p: grant order is p, p+1, ..., wrapping.
- Reset mid-transaction: transaction abandoned, no o_fwd_valid, o_write_enable immediately 0.

Decomposition:
- Shared header (header.v):
  - pADRESS, pMAC_W, pPORTS.
  - Broadcast key constant MAC_BCAST = all-ones pMAC_W.
  - FSM state encodings (IDLE=0, ISSUE=1, WAIT=2, RESP=3).
- One sub-module: rr_arbiter. Inputs: request vector and pointer. Outputs: one-hot grant, binary index, any-grant. Combinational; the pointer register lives in the parent.

Test Plan:
1. Single request, default parameters. Port 2 valid, SA=0x0005, DA=0x0011, table returns 3. Required response:
   - ISSUE cycle: o_hdr_ready=4'b0100, o_write_enable=1 for 1 cycle, o_port_num=2, o_MAC_SA=0x0005, o_MAC_DA=0x0011.
   - Result: o_fwd_valid with src=2, dst=3, flood=0, drop=0.
2. Round-robin. All four ports valid continuously, i_fwd_ready=1, pointer 0 after reset.
   - Grants are 0,1,2,3,0, one grant every 4 cycles.
3. Broadcast. Port 1, DA=0x3FFF, table returns 1.
   - flood=1, dst=0, drop=0; o_write_enable still pulses with SA learned on port 1.
4. Self-forward. Port 3, DA=0x0020, table returns 3.
   - drop=1, dst=3, flood=0.
5. Backpressure. i_fwd_ready held 0 for 10 cycles during RESP.
   - o_fwd_valid and all decision fields stable for 10 cycles.
   - No o_hdr_ready pulse while ports 0 and 1 hold valid; completes on the cycle ready rises.
6. Reset mid-WAIT with pLOOKUP_LAT=4. Assert i_rst_n=0 during WAIT.
   - All outputs 0 immediately; no o_fwd_valid after release.
   - Next request granted to the first valid port at or after port 0.
